snow64_simd_alu_pipe: RTL

//  Pipelined, parametrised SIMD integer ALU; next generation of the Snow64 sub-ALU array.

---
 rtl/snow64_simd_alu_pipe_pkg.sv | 85 ++++++++
 rtl/snow64_simd_alu_pipe_lane64.sv | 134 +++++++++++++
 rtl/snow64_simd_alu_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/snow64_simd_alu_pipe_pkg.sv
// Shared types and helpers for the Snow64 SIMD ALU pipeline.
// Opcodes AddSat/SubSat are only implemented when SNOW64_SIMD_ALU_SATURATE_EN is defined.
package PkgSnow64SimdAlu;

  typedef enum logic [3:0] {
    Add    = 4'd0,
    Sub    = 4'd1,
    Slt    = 4'd2,
    Sltu   = 4'd3,
    And    = 4'd4,
    Orr    = 4'd5,
    Xor    = 4'd6,
    Inv    = 4'd7,
    Not    = 4'd8,
    Shl    = 4'd9,
    Shr    = 4'd10,
    Sra    = 4'd11,
    AddSat = 4'd12,
    SubSat = 4'd13
  } Oper;

  typedef enum logic [1:0] {
    Sz8  = 2'd0,
    Sz16 = 2'd1,
    Sz32 = 2'd2,
    Sz64 = 2'd3
  } TypeSize;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } State;

  // Control half of a pipeline stage; data fields depend on WIDTH/TAG_W
  // and are wrapped around this in the top.
  typedef struct packed {
    Oper     oper;
    TypeSize size;
  } StageCtrl;

  // Byte offset mask inside an element: 0, 1, 3 or 7.
  function automatic logic [2:0] elem_span(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // Bytes that start an element within a 64-bit lane.
  function automatic logic [7:0] elem_lo_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'hFF;
      2'd1:    return 8'h55;
      2'd2:    return 8'h11;
      default: return 8'h01;
    endcase
  endfunction

  // Bytes that end an element within a 64-bit lane.
  function automatic logic [7:0] elem_hi_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'hFF;
      2'd1:    return 8'hAA;
      2'd2:    return 8'h88;
      default: return 8'h80;
    endcase
  endfunction

  // Shift amount field width: log2 of the element bit count.
  function automatic logic [7:0] amt_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h07;
      2'd1:    return 8'h0F;
      2'd2:    return 8'h1F;
      default: return 8'h3F;
    endcase
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == Shl) || (op == Shr) || (op == Sra);
  endfunction

endpackage

// File: rtl/snow64_simd_alu_pipe_lane64.sv
// One 64-bit lane of the SIMD ALU: element arithmetic with a size-masked
// carry chain, plus the single-bit step used by the iterative shifter.
// Saturating ops exist only with SNOW64_SIMD_ALU_SATURATE_EN defined.
module snow64_simd_alu_lane64
  import PkgSnow64SimdAlu::*;
(
  input  logic [3:0]  oper,
  input  logic [1:0]  size,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] res,
  output logic [7:0]  carry,
  output logic [63:0] step_a,
  output logic [63:0] step_b,
  output logic        pending
);

  logic [2:0]  span;
  logic [7:0]  is_lo, is_hi;
  logic [63:0] sum_add, sum_sub;
  logic [7:0]  c_add, c_sub, ez;
  logic        ca, cs;
  logic [2:0]  lo, hi;
  logic        a_sgn, b_sgn, ovf_add, ovf_sub, lt_s, lt_u;
  logic [7:0]  amt, sat_byte;

  assign span  = elem_span(size);
  assign is_lo = elem_lo_mask(size);
  assign is_hi = elem_hi_mask(size);

  // Byte-serial add/sub chains; carries restart at every element's low byte
  always_comb begin
    sum_add = '0;
    sum_sub = '0;
    c_add   = '0;
    c_sub   = '0;
    ca      = 1'b0;
    cs      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (is_lo[i]) begin
        ca = 1'b0;
        cs = 1'b1;
      end
      {ca, sum_add[8*i +: 8]} = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'd0, ca};
      {cs, sum_sub[8*i +: 8]} = {1'b0, a[8*i +: 8]} + {1'b0, ~b[8*i +: 8]} + {8'd0, cs};
      c_add[i] = ca;
      c_sub[i] = cs;
    end
  end

  // Per-byte flag: the element containing this byte is all zero
  always_comb begin
    ez = '0;
    for (int i = 0; i < 8; i++) begin
      ez[i] = 1'b1;
      for (int j = 0; j < 8; j++)
        if ((3'(j) & ~span) == (3'(i) & ~span))
          ez[i] = ez[i] & (a[8*j +: 8] == 8'd0);
    end
  end

  // Result byte selection and one-bit shift step, byte by byte
  always_comb begin
    res      = '0;
    carry    = '0;
    step_a   = a;
    step_b   = b;
    pending  = 1'b0;
    lo       = '0;
    hi       = '0;
    a_sgn    = 1'b0;
    b_sgn    = 1'b0;
    ovf_add  = 1'b0;
    ovf_sub  = 1'b0;
    lt_s     = 1'b0;
    lt_u     = 1'b0;
    amt      = '0;
    sat_byte = '0;
    for (int i = 0; i < 8; i++) begin
      lo       = 3'(i) & ~span;
      hi       = 3'(i) | span;
      a_sgn    = a[{hi, 3'd7}];
      b_sgn    = b[{hi, 3'd7}];
      ovf_add  = (a_sgn == b_sgn) && (sum_add[{hi, 3'd7}] != a_sgn);
      ovf_sub  = (a_sgn != b_sgn) && (sum_sub[{hi, 3'd7}] != a_sgn);
      lt_s     = sum_sub[{hi, 3'd7}] ^ ovf_sub;
      lt_u     = !c_sub[hi];
      sat_byte = is_hi[i] ? (a_sgn ? 8'h80 : 8'h7F) : (a_sgn ? 8'h00 : 8'hFF);
      amt      = b[{lo, 3'd0} +: 8] & amt_mask(size);
      case (oper)
        Add:  begin
          res[8*i +: 8] = sum_add[8*i +: 8];
          carry[i]      = is_hi[i] & c_add[i];
        end
        Sub:  begin
          res[8*i +: 8] = sum_sub[8*i +: 8];
          carry[i]      = is_hi[i] & c_sub[i];
        end
        Slt:  res[8*i +: 8] = {7'd0, is_lo[i] & lt_s};
        Sltu: res[8*i +: 8] = {7'd0, is_lo[i] & lt_u};
        And:  res[8*i +: 8] = a[8*i +: 8] & b[8*i +: 8];
        Orr:  res[8*i +: 8] = a[8*i +: 8] | b[8*i +: 8];
        Xor:  res[8*i +: 8] = a[8*i +: 8] ^ b[8*i +: 8];
        Inv:  res[8*i +: 8] = ~a[8*i +: 8];
        Not:  res[8*i +: 8] = {7'd0, is_lo[i] & ez[i]};
        // Shift operands are shifted in place in S1, so the result is a
        Shl, Shr, Sra: res[8*i +: 8] = a[8*i +: 8];
`ifdef SNOW64_SIMD_ALU_SATURATE_EN
        AddSat: begin
          res[8*i +: 8] = ovf_add ? sat_byte : sum_add[8*i +: 8];
          carry[i]      = is_hi[i] & ovf_add;
        end
        SubSat: begin
          res[8*i +: 8] = ovf_sub ? sat_byte : sum_sub[8*i +: 8];
          carry[i]      = is_hi[i] & ovf_sub;
        end
`endif
        default: ;
      endcase
      if (is_shift(oper) && amt != 8'd0) begin
        pending = 1'b1;
        if (oper == Shl)
          step_a[8*i +: 8] = {a[8*i +: 7], is_lo[i] ? 1'b0 : a[(8*i+63)%64]};
        else
          step_a[8*i +: 8] = {is_hi[i] ? ((oper == Sra) && a_sgn) : a[(8*i+8)%64],
                              a[8*i+1 +: 7]};
        // Amount field sits in the low byte; a nonzero field never borrows out
        if (is_lo[i])
          step_b[8*i +: 8] = b[8*i +: 8] - 8'd1;
      end
    end
  end

endmodule

// File: rtl/snow64_simd_alu_pipe.sv
// Two-stage valid/ready SIMD integer ALU built from WIDTH/64 lanes.
// S1 holds operands (and iterates shifts under the FSM); S2 holds results.
// Optional feature macro: SNOW64_SIMD_ALU_SATURATE_EN (AddSat/SubSat).
module snow64_simd_alu_pipe
  import PkgSnow64SimdAlu::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_oper,
  input  logic [1:0]         in_type_size,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [WIDTH/8-1:0] out_carry,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_busy
);

  localparam int LANES = WIDTH / 64;

  typedef struct packed {
    logic             valid;
    StageCtrl         ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } S1Stage;

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [WIDTH/8-1:0] carry;
    logic [TAG_W-1:0]   tag;
  } S2Stage;

  S1Stage s1;
  S2Stage s2;
  State   state, state_nx;

  logic [LANES-1:0][63:0] lane_res, lane_step_a, lane_step_b;
  logic [LANES-1:0][7:0]  lane_carry;
  logic [LANES-1:0]       lane_pend;
  logic                   pend_any, adv, s1_adv, in_fire;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    snow64_simd_alu_lane64 u_lane (
      .oper    (s1.ctl.oper),
      .size    (s1.ctl.size),
      .a       (s1.a[64*g +: 64]),
      .b       (s1.b[64*g +: 64]),
      .res     (lane_res[g]),
      .carry   (lane_carry[g]),
      .step_a  (lane_step_a[g]),
      .step_b  (lane_step_b[g]),
      .pending (lane_pend[g])
    );
  end

  assign pend_any = |lane_pend;
  assign adv      = !s2.valid || out_ready;
  // Non-shift ops leave S1 as soon as S2 can take them; shifts wait for all counts to drain
  assign s1_adv   = s1.valid && adv && ((state == StIdle) || !pend_any);
  assign in_ready = (state == StIdle) && (!s1.valid || adv);
  assign in_fire  = in_valid && in_ready;

  // S1: capture operands, iterate shift one bit per cycle, release to S2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (in_fire) begin
      s1.valid    <= 1'b1;
      s1.ctl.oper <= Oper'(in_oper);
      s1.ctl.size <= TypeSize'(in_type_size);
      s1.a        <= in_a;
      s1.b        <= in_b;
      s1.tag      <= in_tag;
    end else if (s1_adv) begin
      s1.valid <= 1'b0;
    end else if (s1.valid && state == StShift && pend_any) begin
      s1.a <= lane_step_a;
      s1.b <= lane_step_b;
    end
  end

  // S2: result register; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2 <= '0;
    end else if (adv) begin
      s2.valid <= s1_adv;
      if (s1_adv) begin
        s2.data  <= lane_res;
        s2.carry <= lane_carry;
        s2.tag   <= s1.tag;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= StIdle;
    else        state <= state_nx;
  end

  // FSM next state: enter SHIFT on a shift accept, leave when S1 hands off
  always_comb begin
    state_nx = state;
    case (state)
      StIdle:  if (in_fire && is_shift(in_oper)) state_nx = StShift;
      StShift: if (s1_adv) state_nx = StIdle;
      default: state_nx = StIdle;
    endcase
  end

  assign out_valid = s2.valid;
  assign out_data  = s2.data;
  assign out_carry = s2.carry;
  assign out_tag   = s2.tag;
  assign out_busy  = (state == StShift);

endmodule
